// File: rtl/hpdmc_sdram_emu_if.sv
// Word-level SDRAM pin bundle between the hpdmc controller (master) and the device emulator (slave).
// 'do' is a reserved word in SystemVerilog, so the write data word is carried as dout.
interface hpdmc_sdram_emu_if;
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [1:0]  ba;
    logic [12:0] adr;
    logic        direction;
    logic [3:0]  mo;
    logic [31:0] dout;
    logic [31:0] di;
    logic        rd_valid;

    modport master (
        output cs_n, ras_n, cas_n, we_n, ba, adr, direction, mo, dout,
        input  di, rd_valid
    );

    modport slave (
        input  cs_n, ras_n, cas_n, we_n, ba, adr, direction, mo, dout,
        output di, rd_valid
    );
endinterface

// File: rtl/hpdmc_sdram_emu.sv
// Single-clock DDR SDRAM emulator: decodes controller commands, stores 2-word write bursts,
// returns 2-word read bursts and latches the first protocol violation.
module hpdmc_sdram_emu #(
    parameter int unsigned ROW_BITS = 4,
    parameter int unsigned COL_BITS = 6,
    parameter int unsigned CL_WORDS = 2,
    parameter int unsigned WL_WORDS = 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    hpdmc_sdram_emu_if.slave      bus,
    output logic                  err,
    output logic [2:0]            err_code
);
    localparam int unsigned AW = 2 + ROW_BITS + COL_BITS - 1;

    typedef enum logic [2:0] {
        CMD_LMR = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_t;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] a;
    } slot_t;

    logic [31:0]         r_mem [0:(1<<AW)-1];
    logic [3:0]          r_open;
    logic [ROW_BITS-1:0] r_row [4];
    slot_t               r_rp [CL_WORDS+1];
    slot_t               r_wp [WL_WORDS+1];
    logic                r_col_last;
    logic                r_err;
    logic [2:0]          r_code;

    cmd_t          w_cmd;
    logic          w_bank_open;
    logic [AW-1:0] w_word;
    logic [AW-1:0] w_word_k1;
    logic [2:0]    w_cerr;
    logic [2:0]    w_new_code;
    logic          w_rd_go;
    logic          w_wr_go;
    logic          w_act;
    logic          w_pre;
    slot_t         w_wr_slot;
    slot_t         w_rd_slot;
    logic          w_wr_en;
    logic          w_e5;
    logic [31:0]   w_rd_q;
    logic          w_unused;

    assign w_cmd       = bus.cs_n ? CMD_NOP : cmd_t'({bus.ras_n, bus.cas_n, bus.we_n});
    assign w_bank_open = r_open[bus.ba];
    assign w_word      = {bus.ba, r_row[bus.ba], bus.adr[COL_BITS-1:1]};
    assign w_word_k1   = {w_word[AW-1:1], ~w_word[0]};
    assign w_unused    = ^bus.adr;

    always_comb begin
        w_cerr  = '0;
        w_rd_go = 1'b0;
        w_wr_go = 1'b0;
        w_act   = 1'b0;
        w_pre   = 1'b0;
        case (w_cmd)
            CMD_RD, CMD_WR: begin
                if (!w_bank_open)
                    w_cerr = 3'd1;
                else if (r_col_last)
                    w_cerr = 3'd4;
                else begin
                    w_rd_go = (w_cmd == CMD_RD);
                    w_wr_go = (w_cmd == CMD_WR);
                end
            end
            CMD_ACT: begin
                if (w_bank_open)
                    w_cerr = 3'd2;
                else
                    w_act = 1'b1;
            end
            CMD_PRE: w_pre = 1'b1;
            CMD_REF: if (|r_open) w_cerr = 3'd3;
            CMD_LMR: if (bus.adr[2:0] != 3'b010) w_cerr = 3'd6;
            default: ;
        endcase
    end

    assign w_wr_slot = r_wp[WL_WORDS];
    assign w_rd_slot = r_rp[CL_WORDS];
    assign w_wr_en   = w_wr_slot.v && !sys_rst;
    assign w_e5      = w_wr_en && !bus.direction;

    always_comb begin
        w_new_code = w_cerr;
        if (w_e5 && (w_cerr == 3'd0 || w_cerr > 3'd5))
            w_new_code = 3'd5;
    end

    // Write-first: a write landing this cycle on the word being read is forwarded to di.
    always_comb begin
        w_rd_q = r_mem[w_rd_slot.a];
        if (w_wr_en && (w_wr_slot.a == w_rd_slot.a)) begin
            for (int unsigned i = 0; i < 4; i++)
                if (!bus.mo[i])
                    w_rd_q[8*i +: 8] = bus.dout[8*i +: 8];
        end
    end

    assign bus.di       = w_rd_slot.v ? w_rd_q : '0;
    assign bus.rd_valid = w_rd_slot.v;
    assign err          = r_err;
    assign err_code     = r_code;

    always_ff @(posedge sys_clk) begin
        if (w_wr_en) begin
            for (int unsigned i = 0; i < 4; i++)
                if (!bus.mo[i])
                    r_mem[w_wr_slot.a][8*i +: 8] <= bus.dout[8*i +: 8];
        end
    end

    // Burst word 0 enters at stage 1 and word 1 at stage 0, so word 1 reaches the tap one cycle later.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int unsigned i = 0; i <= CL_WORDS; i++)
                r_rp[i] <= '0;
            for (int unsigned i = 0; i <= WL_WORDS; i++)
                r_wp[i] <= '0;
            for (int unsigned i = 0; i < 4; i++)
                r_row[i] <= '0;
            r_open     <= '0;
            r_col_last <= 1'b0;
            r_err      <= 1'b0;
            r_code     <= '0;
        end else begin
            for (int unsigned i = 1; i <= CL_WORDS; i++)
                r_rp[i] <= r_rp[i-1];
            r_rp[0] <= '0;
            if (w_rd_go) begin
                r_rp[0] <= slot_t'{v: 1'b1, a: w_word_k1};
                r_rp[1] <= slot_t'{v: 1'b1, a: w_word};
            end

            for (int unsigned i = 1; i <= WL_WORDS; i++)
                r_wp[i] <= r_wp[i-1];
            r_wp[0] <= '0;
            if (w_wr_go) begin
                r_wp[0] <= slot_t'{v: 1'b1, a: w_word_k1};
                r_wp[1] <= slot_t'{v: 1'b1, a: w_word};
            end

            r_col_last <= w_rd_go | w_wr_go;

            if (w_act) begin
                r_open[bus.ba] <= 1'b1;
                r_row[bus.ba]  <= bus.adr[ROW_BITS-1:0];
            end
            if (w_pre) begin
                if (bus.adr[10])
                    r_open <= '0;
                else
                    r_open[bus.ba] <= 1'b0;
            end

            if (!r_err && (w_new_code != 3'd0)) begin
                r_err  <= 1'b1;
                r_code <= w_new_code;
            end
        end
    end
endmodule
